// File: rtl/life_sequencer_if.sv
// Handshake bundle between life_sequencer, life_logic and double_buffer.
// master: the sequencer (drives start/swap/buffer select, reads done).
// slave:  the engine/buffer side.
interface life_sequencer_if;
    logic logic_start_out;
    logic logic_done_in;
    logic swap_out;
    logic buf_sel_out;

    modport master (
        output logic_start_out,
        output swap_out,
        output buf_sel_out,
        input  logic_done_in
    );

    modport slave (
        input  logic_start_out,
        input  swap_out,
        input  buf_sel_out,
        output logic_done_in
    );
endinterface

// File: rtl/life_sequencer.sv
// life_sequencer: turns frame ticks plus run/step/speed controls into
// life_logic start pulses, waits for completion, and swaps the double-buffer
// halves on the frame tick that follows completion.
// Optional feature macro: SEQ_WATCHDOG_EN (BUSY-cycle watchdog, error_out).
module life_sequencer #(
    parameter int unsigned ACC_WIDTH        = 8,
    parameter int unsigned LOG_MAX_SPEED    = 8,
    parameter int unsigned DONE_MASK_CYCLES = 4
`ifdef SEQ_WATCHDOG_EN
    ,
    parameter int unsigned WATCHDOG_CYCLES  = 2**20
`endif
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     frame_tick_in,
    input  logic                     run_in,
    input  logic                     step_in,
    input  logic [LOG_MAX_SPEED-1:0] speed_in,
    life_sequencer_if.master         seq_if,
    output logic                     busy_out,
    output logic [15:0]              gen_count_out,
    output logic                     error_out
);

    typedef enum logic [2:0] {IDLE, START, BUSY, WAIT_SWAP, SWAP} state_t;

    localparam int unsigned      MASK_W    = $clog2(DONE_MASK_CYCLES + 1);
    localparam logic [MASK_W-1:0] MASK_LOAD = MASK_W'(DONE_MASK_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [ACC_WIDTH:0]     acc_sum;
    logic                   carry;
    logic                   serve;
    logic                   done_ok;
    logic                   step_pending_q, step_pending_d;
    logic                   gen_pending_q, gen_pending_d;
    logic [MASK_W-1:0]      mask_q, mask_d;
    logic                   start_q, start_d;
    logic                   swap_q, swap_d;
    logic                   buf_sel_q, buf_sel_d;
    logic                   busy_q, busy_d;
    logic [15:0]            gen_count_q, gen_count_d;
    logic                   wd_expired;

`ifdef SEQ_WATCHDOG_EN
    localparam int unsigned     WD_W    = (WATCHDOG_CYCLES > 2) ? $clog2(WATCHDOG_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            error_q, error_d;
`endif

    // Speed accumulator and single-entry trigger flags.
    always_comb begin
        acc_sum = {1'b0, acc_q} + (ACC_WIDTH + 1)'(speed_in);
        acc_d   = acc_q;
        carry   = 1'b0;
        if (frame_tick_in && run_in) begin
            acc_d = acc_sum[ACC_WIDTH-1:0];
            carry = acc_sum[ACC_WIDTH];
        end
        serve = (state_q == IDLE) && (gen_pending_q || step_pending_q);
        // A trigger coinciding with service merges into the generation being
        // launched; user steps are only taken while idle, carries queue anywhere.
        gen_pending_d  = serve ? 1'b0 : (gen_pending_q | carry);
        step_pending_d = serve ? 1'b0 : (step_pending_q | (step_in && (state_q == IDLE)));
    end

    // Next-state logic, done mask and watchdog counting.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        wd_expired = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        wd_d       = wd_q;
`endif
        done_ok    = (mask_q == '0) && seq_if.logic_done_in;
        case (state_q)
            IDLE: begin
                if (serve) state_d = START;
            end
            START: begin
                state_d = BUSY;
                mask_d  = MASK_LOAD;
`ifdef SEQ_WATCHDOG_EN
                wd_d    = '0;
`endif
            end
            BUSY: begin
                if (mask_q != '0) mask_d = mask_q - 1'b1;
                if (done_ok) begin
                    state_d = WAIT_SWAP;
                end
`ifdef SEQ_WATCHDOG_EN
                else if (wd_q == WD_LAST) begin
                    state_d    = IDLE;
                    wd_expired = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            WAIT_SWAP: begin
                if (frame_tick_in) state_d = SWAP;
            end
            SWAP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs derived from the upcoming state.
    always_comb begin
        start_d     = (state_d == START);
        swap_d      = (state_d == SWAP);
        busy_d      = (state_d != IDLE);
        buf_sel_d   = buf_sel_q ^ swap_d;
        gen_count_d = swap_d ? gen_count_q + 16'd1 : gen_count_q;
`ifdef SEQ_WATCHDOG_EN
        error_d     = error_q | wd_expired;
`endif
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Datapath and output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc_q          <= '0;
            step_pending_q <= 1'b0;
            gen_pending_q  <= 1'b0;
            mask_q         <= '0;
            start_q        <= 1'b0;
            swap_q         <= 1'b0;
            buf_sel_q      <= 1'b0;
            busy_q         <= 1'b0;
            gen_count_q    <= '0;
`ifdef SEQ_WATCHDOG_EN
            wd_q           <= '0;
            error_q        <= 1'b0;
`endif
        end else begin
            acc_q          <= acc_d;
            step_pending_q <= step_pending_d;
            gen_pending_q  <= gen_pending_d;
            mask_q         <= mask_d;
            start_q        <= start_d;
            swap_q         <= swap_d;
            buf_sel_q      <= buf_sel_d;
            busy_q         <= busy_d;
            gen_count_q    <= gen_count_d;
`ifdef SEQ_WATCHDOG_EN
            wd_q           <= wd_d;
            error_q        <= error_d;
`endif
        end
    end

    assign seq_if.logic_start_out = start_q;
    assign seq_if.swap_out        = swap_q;
    assign seq_if.buf_sel_out     = buf_sel_q;
    assign busy_out               = busy_q;
    assign gen_count_out          = gen_count_q;
`ifdef SEQ_WATCHDOG_EN
    assign error_out              = error_q;
`else
    assign error_out              = 1'b0;
`endif

endmodule

// File: tb/tb_life_sequencer.sv
// Self-checking bench for life_sequencer: a cycle-by-cycle vector table for
// the step / stale-done case, plus hand-written multi-cycle sequences.
module tb_life_sequencer;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        tick     = 1'b0;
    logic        run      = 1'b0;
    logic        step     = 1'b0;
    logic        done_drv = 1'b0;
    logic [7:0]  speed    = '0;
    logic        busy;
    logic [15:0] gen;
    logic        err;

    life_sequencer_if sif();
    assign sif.logic_done_in = done_drv;

    life_sequencer #(
        .ACC_WIDTH(8),
        .LOG_MAX_SPEED(8),
        .DONE_MASK_CYCLES(4)
`ifdef SEQ_WATCHDOG_EN
        ,
        .WATCHDOG_CYCLES(64)
`endif
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .frame_tick_in(tick),
        .run_in(run),
        .step_in(step),
        .speed_in(speed),
        .seq_if(sif),
        .busy_out(busy),
        .gen_count_out(gen),
        .error_out(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        tick, run, step, done;
        logic        e_start, e_busy, e_swap, e_buf, e_err;
        logic [15:0] e_gen;
    } vec_t;

    vec_t tv [12];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   start_at[$];
    int   swap_at[$];
    int   swap_bad = 0;
    int   busy_cnt = 0;

    task automatic chk_b(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick = 1'b0; run = 1'b0; step = 1'b0; done_drv = 1'b0; speed = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        start_at.delete();
        swap_at.delete();
        swap_bad = 0;
        busy_cnt = 0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        clk1();
        step = 1'b0;
    endtask

    // Drives frame ticks every `period` cycles (0 = none) and answers each
    // start with done after `lat` cycles, held until the next start.
    task automatic run_frames(input int n, input int period, input int lat);
        int since = -1;
        for (int i = 0; i < n; i++) begin
            int c = cyc;
            tick = (period > 0) ? (c % period == period - 1) : 1'b0;
            clk1();
            if (busy) busy_cnt++;
            if (sif.swap_out) begin
                swap_at.push_back(c);
                if (!tick) swap_bad++;
            end
            if (sif.logic_start_out) begin
                start_at.push_back(c);
                since = 0;
                done_drv = 1'b0;
            end else if (since >= 0) begin
                since++;
                if (since == lat) done_drv = 1'b1;
            end
        end
        tick = 1'b0;
    endtask

    initial begin
        // run=0, stale done held high, steps on three consecutive cycles, tick every cycle
        tv[0]  = '{H, L, H, H,  L, L, L, L, L, 16'd0};
        tv[1]  = '{H, L, H, H,  H, H, L, L, L, 16'd0};
        tv[2]  = '{H, L, H, H,  L, H, L, L, L, 16'd0};
        tv[3]  = '{H, L, L, H,  L, H, L, L, L, 16'd0};
        tv[4]  = '{H, L, L, H,  L, H, L, L, L, 16'd0};
        tv[5]  = '{H, L, L, H,  L, H, L, L, L, 16'd0};
        tv[6]  = '{H, L, L, H,  L, H, L, L, L, 16'd0};
        tv[7]  = '{H, L, L, H,  L, H, H, H, L, 16'd1};
        tv[8]  = '{H, L, L, H,  L, L, L, H, L, 16'd1};
        tv[9]  = '{H, L, L, H,  L, L, L, H, L, 16'd1};
        tv[10] = '{L, L, L, L,  L, L, L, H, L, 16'd1};
        tv[11] = '{L, L, L, L,  L, L, L, H, L, 16'd1};

        do_reset();
        chk_b("reset start", sif.logic_start_out, 1'b0);
        chk_b("reset swap", sif.swap_out, 1'b0);
        chk_b("reset buf", sif.buf_sel_out, 1'b0);
        chk_b("reset busy", busy, 1'b0);
        chk_w("reset gen", gen, 16'd0);
        chk_b("reset err", err, 1'b0);

        for (int i = 0; i < 12; i++) begin
            tick = tv[i].tick; run = tv[i].run; step = tv[i].step; done_drv = tv[i].done;
            clk1();
            chk_b($sformatf("vec%0d start", i), sif.logic_start_out, tv[i].e_start);
            chk_b($sformatf("vec%0d busy", i), busy, tv[i].e_busy);
            chk_b($sformatf("vec%0d swap", i), sif.swap_out, tv[i].e_swap);
            chk_b($sformatf("vec%0d buf", i), sif.buf_sel_out, tv[i].e_buf);
            chk_b($sformatf("vec%0d err", i), err, tv[i].e_err);
            chk_w($sformatf("vec%0d gen", i), gen, tv[i].e_gen);
        end

        // Free run at half speed: starts on every second tick, swap on the next tick
        do_reset();
        run = 1'b1; speed = 8'd128;
        run_frames(330, 30, 10);
        chk_i("run starts", start_at.size(), 5);
        chk_i("run swaps", swap_at.size(), 5);
        chk_i("run swap off tick", swap_bad, 0);
        for (int i = 0; i < 5; i++) begin
            if (i < start_at.size()) chk_i($sformatf("run start%0d", i), start_at[i], 60 * (i + 1));
            if (i < swap_at.size())  chk_i($sformatf("run swap%0d", i), swap_at[i], 60 * (i + 1) + 29);
        end
        chk_w("run gen", gen, 16'd5);
        chk_b("run buf", sif.buf_sel_out, 1'b1);
        chk_b("run err", err, 1'b0);

        // Full speed with generations longer than a frame: a single queued generation
        do_reset();
        run = 1'b1; speed = 8'd255;
        run_frames(40, 8, 20);
        run = 1'b0;
        run_frames(40, 8, 20);
        chk_i("fast starts", start_at.size(), 2);
        chk_i("fast swaps", swap_at.size(), 2);
        if (start_at.size() == 2 && swap_at.size() >= 1)
            chk_i("fast restart gap", start_at[1] - swap_at[0], 2);
        if (start_at.size() >= 1) chk_i("fast first start", start_at[0], 16);
        chk_w("fast gen", gen, 16'd2);
        chk_b("fast buf", sif.buf_sel_out, 1'b0);

        // Asynchronous reset in the middle of BUSY
        run_frames(2, 0, 1000);
        pulse_step();
        clk1();
        clk1();
        chk_b("pre-reset busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_b("async busy", busy, 1'b0);
        chk_b("async start", sif.logic_start_out, 1'b0);
        chk_b("async swap", sif.swap_out, 1'b0);
        chk_b("async buf", sif.buf_sel_out, 1'b0);
        chk_w("async gen", gen, 16'd0);
        chk_b("async err", err, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0; start_at.delete(); swap_at.delete(); swap_bad = 0; busy_cnt = 0;
        run_frames(40, 10, 10);
        chk_i("post-reset swaps", swap_at.size(), 0);
        chk_i("post-reset busy", busy_cnt, 0);
        pulse_step();
        run_frames(40, 10, 10);
        chk_i("post-reset starts", start_at.size(), 1);
        chk_i("post-reset swap count", swap_at.size(), 1);
        chk_w("post-reset gen", gen, 16'd1);
        chk_b("post-reset buf", sif.buf_sel_out, 1'b1);

`ifdef SEQ_WATCHDOG_EN
        // Done never returned: watchdog abandons the generation after 64 BUSY cycles
        do_reset();
        pulse_step();
        run_frames(99, 0, 1000000);
        chk_i("wd busy cycles", busy_cnt, 65);
        chk_b("wd err", err, 1'b1);
        chk_b("wd idle", busy, 1'b0);
        chk_i("wd swaps", swap_at.size(), 0);
        chk_w("wd gen", gen, 16'd0);
        pulse_step();
        run_frames(40, 10, 10);
        chk_i("wd retry swaps", swap_at.size(), 1);
        chk_w("wd retry gen", gen, 16'd1);
        chk_b("wd err sticky", err, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
